// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arb_pkg                                                                |
// | Shared types and constants for the fetch/data memory port arbiter.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

  localparam int ADDR_W_DFLT  = 16;
  localparam int DATA_W_DFLT  = 16;
  localparam int STARVE_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/arb_starve_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arb_starve_counter                                                         |
// | Saturating count of data grants taken while a fetch was waiting.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,      // active low
  input  logic i_inc,
  input  logic i_clr,
  output logic o_atLimit
);

  localparam logic [STARVE_CNT_W-1:0] c_limit = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] r_count;

  // Clear wins over increment: a fetch grant always resets the fairness window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != c_limit)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_atLimit = (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter                                                           |
// | Shares one single-ported memory between fetch and data stages; data wins  |
// | ties. Define MEM_ARB_STARVE_EN to force a fetch grant after STARVE_LIMIT   |
// | consecutive data grants with fetch waiting.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DFLT,
  parameter int DATA_W       = DATA_W_DFLT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active low
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem
);

  arb_state_t        r_state;
  arb_state_t        w_nextState;
  logic              w_grantIf;
  logic              w_grantD;
  logic              w_atLimit;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ifReady;
  logic              r_dReady;
  logic [DATA_W-1:0] r_ifRdata;
  logic [DATA_W-1:0] r_dRdata;

`ifdef MEM_ARB_STARVE_EN
  logic w_starveInc;
  logic w_starveClr;

  assign w_starveInc = w_grantD & if_req;
  assign w_starveClr = w_grantIf | ((r_state == ARB_IDLE) & ~if_req);

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starveCounter (
    .clk       (clk),
    .reset     (reset),
    .i_inc     (w_starveInc),
    .i_clr     (w_starveClr),
    .o_atLimit (w_atLimit)
  );
`else
  assign w_atLimit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Grants are only decided in ARB_IDLE, so an outstanding access is never preempted.
  always_comb begin
    w_nextState = r_state;
    w_grantIf   = 1'b0;
    w_grantD    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (d_req && !(if_req && w_atLimit)) begin
          w_grantD    = 1'b1;
          w_nextState = ARB_D;
        end else if (if_req) begin
          w_grantIf   = 1'b1;
          w_nextState = ARB_IF;
        end
      end
      ARB_IF, ARB_D: begin
        if (mem_ack) begin
          w_nextState = ARB_IDLE;
        end
      end
      default: begin
        w_nextState = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_ifReady <= 1'b0;
      r_dReady  <= 1'b0;
      r_ifRdata <= '0;
      r_dRdata  <= '0;
    end else begin
      r_ifReady <= 1'b0;
      r_dReady  <= 1'b0;
      if (w_grantIf) begin
        r_addr  <= if_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
      end else if (w_grantD) begin
        r_addr  <= d_addr;
        r_we    <= d_we;
        r_wdata <= d_wdata;
      end
      if ((r_state == ARB_IF) && mem_ack) begin
        r_ifReady <= 1'b1;
        r_ifRdata <= mem_rdata;
      end
      // Stores complete without disturbing the last loaded value.
      if ((r_state == ARB_D) && mem_ack) begin
        r_dReady <= 1'b1;
        if (!r_we) begin
          r_dRdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (r_state != ARB_IDLE);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_ifRdata;
  assign if_ready  = r_ifReady;
  assign d_rdata   = r_dRdata;
  assign d_ready   = r_dReady;
  assign stall_if  = if_req & ~r_ifReady;
  assign stall_mem = d_req & ~r_dReady;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                        |
// | Directed scoreboard bench for mem_port_arbiter with a wait-state memory.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] d_rdata;
  logic        d_ready;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall_if;
  logic        stall_mem;

  exp_t        ifQ[$];
  exp_t        dQ[$];
  logic [15:0] memArr [logic [15:0]];
  int          checks = 0;
  int          errors = 0;
  int          ackDelay = 0;
  int          waitCnt = 0;
  string       grantLog = "";
  int          cyc = 0;
  int          grantCyc = 0;
  int          enCycles = 0;
  int          lastEnCycles = 0;
  int          ifGrantCyc = -1;
  int          dReadyCyc = -1;
  logic        prevEn = 1'b0;
  logic [15:0] gAddr = '0;
  logic [15:0] gWdata = '0;
  logic        gWe = 1'b0;
  logic [15:0] dRdataModel = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (16),
    .STARVE_LIMIT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkStr(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] memRead(input logic [15:0] a);
    if (memArr.exists(a)) return memArr[a];
    return a ^ 16'hA5A5;
  endfunction

  // Memory: acks after ackDelay wait cycles, drops ack once the access retires.
  always @(negedge clk) begin
    if (!reset || !mem_en || mem_ack) begin
      mem_ack = 1'b0;
      waitCnt = 0;
    end else if (waitCnt >= ackDelay) begin
      mem_ack   = 1'b1;
      mem_rdata = memRead(mem_addr);
      if (mem_we) memArr[mem_addr] = mem_wdata;
    end else begin
      waitCnt++;
    end
  end

  // Monitor: records each grant, checks it stays stable, scores every ready pulse.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (mem_en && !prevEn) begin
      gAddr    = mem_addr;
      gWe      = mem_we;
      gWdata   = mem_wdata;
      grantCyc = cyc;
      enCycles = 1;
    end else if (mem_en) begin
      enCycles++;
      chk("hold_addr", 32'(mem_addr), 32'(gAddr));
      chk("hold_we", 32'(mem_we), 32'(gWe));
      chk("hold_wdata", 32'(mem_wdata), 32'(gWdata));
    end
    prevEn = mem_en;
    if (if_ready) begin
      checks++;
      assert (ifQ.size() > 0) else begin
        errors++;
        $error("FAIL if_ready_extra: observed pulse expected none");
      end
      if (ifQ.size() > 0) begin
        e = ifQ.pop_front();
        chk("if_mem_addr", 32'(gAddr), 32'(e.addr));
        chk("if_mem_we", 32'(gWe), 0);
        chk("if_rdata", 32'(if_rdata), 32'(e.rdata));
      end
      grantLog     = {grantLog, "I"};
      ifGrantCyc   = grantCyc;
      lastEnCycles = enCycles;
    end
    if (d_ready) begin
      checks++;
      assert (dQ.size() > 0) else begin
        errors++;
        $error("FAIL d_ready_extra: observed pulse expected none");
      end
      if (dQ.size() > 0) begin
        e = dQ.pop_front();
        chk("d_mem_addr", 32'(gAddr), 32'(e.addr));
        chk("d_mem_we", 32'(gWe), 32'(e.we));
        if (e.we) chk("d_mem_wdata", 32'(gWdata), 32'(e.wdata));
        chk("d_rdata", 32'(d_rdata), 32'(e.rdata));
      end
      grantLog     = {grantLog, "D"};
      dReadyCyc    = cyc;
      lastEnCycles = enCycles;
    end
  end

  task automatic pushIf(input logic [15:0] a);
    exp_t e;
    e.addr = a; e.we = 1'b0; e.wdata = '0; e.rdata = memRead(a);
    ifQ.push_back(e);
  endtask

  task automatic pushD(input logic [15:0] a, input logic we, input logic [15:0] wd);
    exp_t e;
    if (!we) dRdataModel = memRead(a);
    e.addr = a; e.we = we; e.wdata = wd; e.rdata = dRdataModel;
    dQ.push_back(e);
  endtask

  // Holds the current requests until each has seen the wanted number of ready pulses.
  task automatic runReqs(input int nIf, input int nD, input int budget);
    int ifCnt = 0;
    int dCnt = 0;
    for (int c = 0; c < budget && (ifCnt < nIf || dCnt < nD); c++) begin
      @(negedge clk);
      chk("stall_if", 32'(stall_if), 32'(if_req & ~if_ready));
      chk("stall_mem", 32'(stall_mem), 32'(d_req & ~d_ready));
      if (if_ready) begin
        ifCnt++;
        if (ifCnt >= nIf) if_req = 1'b0;
      end
      if (d_ready) begin
        dCnt++;
        if (dCnt >= nD) begin
          d_req = 1'b0;
          d_we  = 1'b0;
        end
      end
    end
    chk("if_ready_count", 32'(ifCnt), 32'(nIf));
    chk("d_ready_count", 32'(dCnt), 32'(nD));
    #1;
  endtask

  initial begin
    memArr[16'h0010] = 16'hABCD;
    memArr[16'h0300] = 16'h5A5A;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_if_ready", 32'(if_ready), 0);
    chk("rst_d_ready", 32'(d_ready), 0);
    chk("rst_if_rdata", 32'(if_rdata), 0);
    chk("rst_d_rdata", 32'(d_rdata), 0);
    chk("rst_stalls", 32'({stall_if, stall_mem}), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Fetch only, one wait cycle
    ackDelay = 1;
    if_addr  = 16'h0010;
    pushIf(16'h0010);
    if_req = 1'b1;
    @(negedge clk);
    chk("fetch_latency_en", 32'(mem_en), 1);
    chk("fetch_stall", 32'(stall_if), 1);
    runReqs(1, 0, 20);
    chk("fetch_rdata_kept", 32'(if_rdata), 32'h0000ABCD);
    chk("fetch_ifq_empty", 32'(ifQ.size()), 0);

    // Store leaves d_rdata untouched
    ackDelay = 0;
    d_addr = 16'h0200; d_wdata = 16'h1234; d_we = 1'b1;
    pushD(16'h0200, 1'b1, 16'h1234);
    d_req = 1'b1;
    runReqs(0, 1, 20);
    chk("store_d_rdata", 32'(d_rdata), 0);
    chk("store_dq_empty", 32'(dQ.size()), 0);

    // Tie: data first, fetch granted at the edge ending d_ready
    @(negedge clk);
    grantLog = "";
    d_addr = 16'h0300; d_we = 1'b0;
    if_addr = 16'h0014;
    pushD(16'h0300, 1'b0, 16'h0000);
    pushIf(16'h0014);
    d_req = 1'b1; if_req = 1'b1;
    runReqs(1, 1, 40);
    chkStr("tie_order", grantLog, "DI");
    chk("tie_if_after_d", 32'(ifGrantCyc), 32'(dReadyCyc + 1));
    chk("tie_d_rdata", 32'(d_rdata), 32'h00005A5A);

    // Both requests held continuously
    @(negedge clk);
    grantLog = "";
    d_addr = 16'h0400; d_we = 1'b0;
    if_addr = 16'h0020;
    for (int i = 0; i < 6; i++) pushD(16'h0400, 1'b0, 16'h0000);
    pushIf(16'h0020);
    d_req = 1'b1; if_req = 1'b1;
    runReqs(1, 6, 100);
`ifdef MEM_ARB_STARVE_EN
    chkStr("starve_order", grantLog, "DDDDIDD");
`else
    chkStr("strict_order", grantLog, "DDDDDDI");
`endif
    chk("starve_queues_empty", 32'(ifQ.size() + dQ.size()), 0);

    // Five wait states: six stable cycles, one ready
    @(negedge clk);
    ackDelay = 5;
    d_addr = 16'h0500; d_wdata = 16'hBEEF; d_we = 1'b1;
    pushD(16'h0500, 1'b1, 16'hBEEF);
    d_req = 1'b1;
    runReqs(0, 1, 40);
    chk("wait_en_cycles", 32'(lastEnCycles), 6);
    chk("wait_dq_empty", 32'(dQ.size()), 0);

    // Reset in the second cycle of a data access
    @(negedge clk);
    ackDelay = 10;
    d_addr = 16'h0600; d_we = 1'b0;
    d_req = 1'b1;
    @(negedge clk);
    chk("abort_en_c1", 32'(mem_en), 1);
    @(negedge clk);
    reset = 1'b0;
    dRdataModel = '0;
    #1;
    chk("abort_en_drop", 32'(mem_en), 0);
    chk("abort_addr_clr", 32'(mem_addr), 0);
    chk("abort_d_ready", 32'(d_ready), 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold_en", 32'(mem_en), 0);
      chk("abort_hold_ready", 32'(d_ready), 0);
    end
    ackDelay = 0;
    pushD(16'h0600, 1'b0, 16'h0000);
    reset = 1'b1;
    runReqs(0, 1, 20);
    chk("reissue_d_rdata", 32'(d_rdata), 32'(16'h0600 ^ 16'hA5A5));
    chk("final_queues_empty", 32'(ifQ.size() + dQ.size()), 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-ported 16-bit unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline. Sequences each access as a req/ack transaction to the memory and returns per-requester ready pulses and stall signals that freeze the corresponding pipeline stage. Data requests win by default, and a starvation guard keeps fetch from being locked out indefinitely.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- STARVE_LIMIT, 4, number of consecutive data grants with fetch pending before fetch is forced (range 1..15)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request, held until if_ready
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_rdata  out  DATA_W  fetched word, registered
- if_ready  out  1  one-cycle pulse: if_rdata valid, fetch done
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, registered
- d_ready  out  1  one-cycle pulse: data access done
- mem_en  out  1  memory access strobe, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled only while mem_en
- stall_if  out  1  if_req & ~if_ready
- stall_mem  out  1  d_req & ~d_ready

## Operation
- FSM states: ARB_IDLE, ARB_IF, ARB_D.
- ARB_IDLE: if only d_req, go to ARB_D; if only if_req, go to ARB_IF; if both, go to ARB_D unless the starvation counter equals STARVE_LIMIT, in which case go to ARB_IF; if neither, stay.
- On leaving ARB_IDLE, latch the address, the write enable and the write data of the winner into registers; mem_* are driven from these registers only.
- ARB_IF/ARB_D: mem_en=1, mem_we = latched d_we (0 in ARB_IF). Wait for mem_ack, with no timeout.
- On mem_ack: capture mem_rdata into if_rdata or d_rdata. Stores do not update d_rdata. Pulse the matching ready for one cycle. Return to ARB_IDLE.
- Starvation counter: on a data grant with if_req=1, increment, saturating at STARVE_LIMIT. Clear it on any fetch grant, or in ARB_IDLE when if_req=0.
- A request dropped before its grant is ignored. A request dropped during its grant still completes, and its ready still pulses.
- No new grant is issued while a transaction is outstanding.

## Timing
- Reset values: state ARB_IDLE, counter 0, all outputs 0 (rdata registers 0).
- Reset asserted mid-transaction abandons the transaction immediately. mem_en drops asynchronously and the memory must tolerate the abort.
- Request seen in ARB_IDLE at edge N: mem_en is high from cycle N+1.
- mem_ack in cycle M: ready and rdata valid in cycle M+1, and the FSM is in ARB_IDLE in M+1.
- Minimum access takes 3 cycles from request to ready (ack in the first grant cycle).
- The earliest next grant is the edge at the end of the ready cycle. A requester must deassert or change its req at that edge to avoid a duplicate access.
- stall_if and stall_mem are combinational from req inputs and registered ready.

## Configuration
- MEM_ARB_STARVE_EN defined: starvation counter and forced fetch grant as above.
- MEM_ARB_STARVE_EN undefined: the counter logic is absent and data always wins ties (strict priority). STARVE_LIMIT is then ignored.

## Structure
- Package mem_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_IF, ARB_D};
  - ADDR_W/DATA_W defaults;
  - STARVE_CNT_W = 4.
- Sub-module arb_starve_counter: saturating counter with inc, clr and at_limit. It is instantiated only under MEM_ARB_STARVE_EN.

## Test plan
- Fetch only: if_req=1, if_addr=0x0010, memory acks 1 cycle after mem_en with 0xABCD -> mem_addr=0x0010, mem_we=0, if_ready pulses once, if_rdata=0xABCD, stall_if high until the ready cycle.
- Store: d_req=1, d_we=1, d_addr=0x0200, d_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234, d_ready pulses once, d_rdata unchanged at 0.
- Tie: if_req and d_req raised in the same cycle (load 0x0300) -> data granted first, fetch granted right after d_ready, stall_if held across both accesses.
- Starvation (MEM_ARB_STARVE_EN, STARVE_LIMIT=4): d_req and if_req held high continuously -> grant order D,D,D,D,IF,D...; without the macro, IF is never granted while d_req is held.
- Wait states: mem_ack delayed 5 cycles -> mem_en, mem_addr and mem_wdata stay stable for all 6 cycles, and exactly one ready pulse.
- Reset mid-access: reset driven low in the 2nd cycle of ARB_D -> mem_en=0 at once, FSM in ARB_IDLE, no ready pulse; after release, the held d_req is reissued and completes.
